// File: rtl/arbitro_bloco_operativo.sv
// Round-robin arbiter sharing one polynomial datapath and its control block between two requesters.
// Optional WAIT timeout with control-block recovery is enabled by defining ARB_TIMEOUT_EN.
module arbitro_bloco_operativo #(
    parameter int unsigned W       = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_req0,
    input  logic         i_req1,
    input  logic [W-1:0] i_x0,
    input  logic [W-1:0] i_x1,
    output logic         o_ack0,
    output logic         o_ack1,
    output logic [W-1:0] o_res,
    output logic         o_erro,
    output logic         o_ocupado,
    output logic [W-1:0] o_x_dp,
    output logic         o_inicio,
    input  logic         i_comecou,
    input  logic         i_pronto,
    input  logic [W-1:0] i_res_dp,
    output logic         o_rst_ctrl
);

    localparam int unsigned CNT_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_WAIT,
        S_DONE
`ifdef ARB_TIMEOUT_EN
        , S_ABORT
`endif
    } state_t;

    state_t r_state;
    logic   r_ult;
    logic   r_gnt;
    logic   w_pick1;

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    logic [CNT_W-1:0] r_cnt;
`else
    logic [CNT_W-1:0] w_unused_timeout;
    assign w_unused_timeout = CNT_W'(TIMEOUT);
`endif

    // Requester 1 wins alone, or on contention when requester 0 was served last.
    assign w_pick1 = i_req1 & (~i_req0 | ~r_ult);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_ult      <= 1'b1;
            r_gnt      <= 1'b0;
            o_ack0     <= 1'b0;
            o_ack1     <= 1'b0;
            o_res      <= '0;
            o_erro     <= 1'b0;
            o_ocupado  <= 1'b0;
            o_x_dp     <= '0;
            o_inicio   <= 1'b0;
            o_rst_ctrl <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_cnt      <= '0;
`endif
        end else begin
            o_inicio   <= 1'b0;
            o_ack0     <= 1'b0;
            o_ack1     <= 1'b0;
            o_erro     <= 1'b0;
            o_rst_ctrl <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if ((i_req0 | i_req1) && i_comecou) begin
                        r_gnt     <= w_pick1;
                        r_ult     <= w_pick1;
                        o_x_dp    <= w_pick1 ? i_x1 : i_x0;
                        o_inicio  <= 1'b1;
                        o_ocupado <= 1'b1;
                        r_state   <= S_GRANT;
                    end
                end
                S_GRANT: begin
`ifdef ARB_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_pronto) begin
                        o_res   <= i_res_dp;
                        o_ack0  <= ~r_gnt;
                        o_ack1  <= r_gnt;
                        r_state <= S_DONE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (r_cnt == TIMEOUT_C) begin
                        o_rst_ctrl <= 1'b1;
                        r_state    <= S_ABORT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end
`ifdef ARB_TIMEOUT_EN
                S_ABORT: begin
                    o_res   <= '0;
                    o_ack0  <= ~r_gnt;
                    o_ack1  <= r_gnt;
                    o_erro  <= 1'b1;
                    r_state <= S_DONE;
                end
`endif
                S_DONE: begin
                    o_ocupado <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    o_ocupado <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_bloco_operativo.sv
// Directed self-checking bench for arbitro_bloco_operativo with a behavioural control-block model.
module tb_arbitro_bloco_operativo;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0 = 1'b0;
    logic         req1 = 1'b0;
    logic [W-1:0] x0 = '0;
    logic [W-1:0] x1 = '0;
    logic         ack0, ack1, erro, ocupado, inicio, rst_ctrl;
    logic [W-1:0] res, x_dp, res_dp;
    logic         comecou, pronto;

    logic [3:0]   cb_cnt = 4'd0;
    logic         cb_busy = 1'b0;
    logic         pronto_en = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    arbitro_bloco_operativo #(.W(W), .TIMEOUT(15)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_req0(req0), .i_req1(req1), .i_x0(x0), .i_x1(x1),
        .o_ack0(ack0), .o_ack1(ack1), .o_res(res), .o_erro(erro),
        .o_ocupado(ocupado), .o_x_dp(x_dp), .o_inicio(inicio),
        .i_comecou(comecou), .i_pronto(pronto), .i_res_dp(res_dp),
        .o_rst_ctrl(rst_ctrl)
    );

    // Control block: state 0 idle, pronto in state 8, one trailing state before idle again.
    assign comecou = (cb_cnt == 4'd0) && !cb_busy;
    assign pronto  = (cb_cnt == 4'd8) && pronto_en;
    assign res_dp  = pronto ? (x_dp * x_dp * x_dp + x_dp * x_dp + 16'd1) : 16'hDEAD;

    always @(posedge clk) begin
        if (reset || rst_ctrl)        cb_cnt <= 4'd0;
        else if (cb_cnt == 4'd0) begin
            if (inicio && !cb_busy)   cb_cnt <= 4'd1;
        end
        else if (cb_cnt == 4'd9)      cb_cnt <= 4'd0;
        else                          cb_cnt <= cb_cnt + 4'd1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req0 = 1'b1; x0 = 16'h0005;
        step(); step();
        n_vec++;
        if ({ack0, ack1, erro, ocupado, inicio, rst_ctrl} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags: got %b expected 000000", {ack0, ack1, erro, ocupado, inicio, rst_ctrl});
        end
        n_vec++;
        if (res !== 16'h0000) begin n_err++; $display("FAIL reset_res: got %h expected 0000", res); end
        n_vec++;
        if (x_dp !== 16'h0000) begin n_err++; $display("FAIL reset_x_dp: got %h expected 0000", x_dp); end
        reset = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            n_vec++;
            if (inicio !== (c == 1)) begin n_err++; $display("FAIL reset_inicio c%0d: got %b expected %b", c, inicio, (c == 1)); end
            if (c == 1) begin
                n_vec++;
                if (x_dp !== 16'h0005) begin n_err++; $display("FAIL reset_x_dp_grant: got %h expected 0005", x_dp); end
            end
            if (c == 10) begin
                n_vec++;
                if (ack0 !== 1'b1 || res !== 16'h0097) begin
                    n_err++; $display("FAIL reset_first_ack: got ack0=%b res=%h expected ack0=1 res=0097", ack0, res);
                end
                req0 = 1'b0;
            end
        end
        step();
    endtask

    task automatic test_single();
        req0 = 1'b1; x0 = 16'h0003;
        for (int c = 1; c <= 10; c++) begin
            step();
            n_vec++;
            if (inicio !== (c == 1)) begin n_err++; $display("FAIL single_inicio c%0d: got %b expected %b", c, inicio, (c == 1)); end
            n_vec++;
            if (ack0 !== (c == 10)) begin n_err++; $display("FAIL single_ack0 c%0d: got %b expected %b", c, ack0, (c == 10)); end
            if (c == 1) begin
                n_vec++;
                if (x_dp !== 16'h0003) begin n_err++; $display("FAIL single_x_dp: got %h expected 0003", x_dp); end
            end
            if (c == 10) begin
                n_vec++;
                if (res !== 16'h0025) begin n_err++; $display("FAIL single_res: got %h expected 0025", res); end
                n_vec++;
                if (erro !== 1'b0 || ack1 !== 1'b0) begin
                    n_err++; $display("FAIL single_erro_ack1: got erro=%b ack1=%b expected 0 0", erro, ack1);
                end
                req0 = 1'b0;
            end
        end
        step();
    endtask

    task automatic test_busy();
        cb_busy = 1'b1; req1 = 1'b1; x1 = 16'h0002;
        for (int c = 1; c <= 15; c++) begin
            step();
            n_vec++;
            if (inicio !== (c == 6)) begin n_err++; $display("FAIL busy_inicio c%0d: got %b expected %b", c, inicio, (c == 6)); end
            n_vec++;
            if (ack1 !== (c == 15)) begin n_err++; $display("FAIL busy_ack1 c%0d: got %b expected %b", c, ack1, (c == 15)); end
            if (c == 3) begin
                n_vec++;
                if (ocupado !== 1'b0) begin n_err++; $display("FAIL busy_ocupado_idle: got %b expected 0", ocupado); end
            end
            if (c == 5) cb_busy = 1'b0;
            if (c == 6) begin
                n_vec++;
                if (x_dp !== 16'h0002) begin n_err++; $display("FAIL busy_x_dp: got %h expected 0002", x_dp); end
            end
            if (c == 15) begin
                n_vec++;
                if (res !== 16'h000D) begin n_err++; $display("FAIL busy_res: got %h expected 000d", res); end
                req1 = 1'b0;
            end
        end
        step();
    endtask

    task automatic test_contention();
        logic exp_ack0, exp_ack1, exp_ini;
        req0 = 1'b1; req1 = 1'b1; x0 = 16'h0001; x1 = 16'h0002;
        for (int c = 1; c <= 32; c++) begin
            step();
            exp_ini  = (c == 1) || (c == 12) || (c == 23);
            exp_ack0 = (c == 10) || (c == 32);
            exp_ack1 = (c == 21);
            n_vec++;
            if (inicio !== exp_ini) begin n_err++; $display("FAIL cont_inicio c%0d: got %b expected %b", c, inicio, exp_ini); end
            n_vec++;
            if ({ack0, ack1} !== {exp_ack0, exp_ack1}) begin
                n_err++; $display("FAIL cont_acks c%0d: got %b%b expected %b%b", c, ack0, ack1, exp_ack0, exp_ack1);
            end
            if (c == 1 || c == 23) begin
                n_vec++;
                if (x_dp !== 16'h0001) begin n_err++; $display("FAIL cont_x_dp c%0d: got %h expected 0001", c, x_dp); end
            end
            if (c == 12) begin
                n_vec++;
                if (x_dp !== 16'h0002) begin n_err++; $display("FAIL cont_x_dp c%0d: got %h expected 0002", c, x_dp); end
            end
            if (c == 10 || c == 32) begin
                n_vec++;
                if (res !== 16'h0003) begin n_err++; $display("FAIL cont_res c%0d: got %h expected 0003", c, res); end
            end
            if (c == 21) begin
                n_vec++;
                if (res !== 16'h000D) begin n_err++; $display("FAIL cont_res c%0d: got %h expected 000d", c, res); end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_wait();
        req0 = 1'b1; x0 = 16'h0003;
        for (int c = 1; c <= 5; c++) step();
        n_vec++;
        if (ocupado !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before: got %b expected 1", ocupado); end
        reset = 1'b1; req0 = 1'b0;
        step();
        reset = 1'b0;
        n_vec++;
        if ({ocupado, ack0, ack1, inicio} !== 4'b0) begin
            n_err++; $display("FAIL midrst_after: got ocupado/ack0/ack1/inicio=%b expected 0000", {ocupado, ack0, ack1, inicio});
        end
        for (int c = 7; c <= 20; c++) begin
            step();
            n_vec++;
            if ({ack0, ack1} !== 2'b00) begin n_err++; $display("FAIL midrst_no_ack c%0d: got %b%b expected 00", c, ack0, ack1); end
        end
        req1 = 1'b1; x1 = 16'h0001;
        for (int c = 1; c <= 10; c++) begin
            step();
            n_vec++;
            if (inicio !== (c == 1)) begin n_err++; $display("FAIL midrst_req1_inicio c%0d: got %b expected %b", c, inicio, (c == 1)); end
            if (c == 10) begin
                n_vec++;
                if (ack1 !== 1'b1 || res !== 16'h0003) begin
                    n_err++; $display("FAIL midrst_req1_ack: got ack1=%b res=%h expected 1 0003", ack1, res);
                end
                req1 = 1'b0;
            end
        end
        step();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        pronto_en = 1'b0; req0 = 1'b1; x0 = 16'h0002;
        for (int c = 1; c <= 19; c++) begin
            step();
            n_vec++;
            if (rst_ctrl !== (c == 18)) begin n_err++; $display("FAIL tmo_rst_ctrl c%0d: got %b expected %b", c, rst_ctrl, (c == 18)); end
            n_vec++;
            if (ack0 !== (c == 19)) begin n_err++; $display("FAIL tmo_ack0 c%0d: got %b expected %b", c, ack0, (c == 19)); end
            if (c == 19) begin
                n_vec++;
                if (erro !== 1'b1 || res !== 16'h0000) begin
                    n_err++; $display("FAIL tmo_erro_res: got erro=%b res=%h expected 1 0000", erro, res);
                end
                req0 = 1'b0;
            end
        end
        pronto_en = 1'b1;
        step();
    endtask
`else
    task automatic test_hold();
        pronto_en = 1'b0; req0 = 1'b1; x0 = 16'h0002;
        for (int c = 1; c <= 40; c++) begin
            step();
            n_vec++;
            if ({ack0, ack1, erro, rst_ctrl} !== 4'b0) begin
                n_err++; $display("FAIL hold_quiet c%0d: got ack0/ack1/erro/rst_ctrl=%b expected 0000", c, {ack0, ack1, erro, rst_ctrl});
            end
        end
        n_vec++;
        if (ocupado !== 1'b1) begin n_err++; $display("FAIL hold_ocupado: got %b expected 1", ocupado); end
        req0 = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0; pronto_en = 1'b1;
        step();
        n_vec++;
        if (ocupado !== 1'b0) begin n_err++; $display("FAIL hold_reset_idle: got %b expected 0", ocupado); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_busy();
        test_contention();
        test_reset_mid_wait();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_hold();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

endmodule
